// File: rtl/sevenseg_scan_driver.sv
// Latches a 16-bit value and scans it as four hex digits on a common-anode display.
// Outputs are registered one cycle behind the scan state; a blanking gap separates slots.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES)
                         ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                         : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int PW = $clog2(MAX_CNT);
  localparam logic [PW-1:0] SCAN_TC  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_TC = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {SCAN = 1'b0, BLANK = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    digit_idx, digit_idx_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic [15:0]   shadow;
  logic [3:0]    nibble;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign nibble = shadow[{digit_idx, 2'b00} +: 4];
  assign dp     = 1'b1;

  always_comb begin
    state_nxt     = state;
    digit_idx_nxt = digit_idx;
    prescaler_nxt = prescaler + 1'b1;
    an_nxt        = 4'b1111;
    seg_nxt       = 7'b1111111;
    case (state)
      SCAN: begin
        if (!blank_mask[digit_idx]) begin
          an_nxt  = ~(4'b0001 << digit_idx);
          seg_nxt = hex_glyph(nibble);
        end
        if (prescaler == SCAN_TC) begin
          prescaler_nxt = '0;
          if (BLANK_CYCLES > 0) begin
            state_nxt = BLANK;
          end else begin
            digit_idx_nxt = digit_idx + 2'd1;
          end
        end
      end
      default: begin
        if (prescaler == BLANK_TC) begin
          prescaler_nxt = '0;
          digit_idx_nxt = digit_idx + 2'd1;
          state_nxt     = SCAN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      digit_idx <= 2'd0;
      prescaler <= '0;
      shadow    <= 16'h0000;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
    end else begin
      state     <= state_nxt;
      digit_idx <= digit_idx_nxt;
      prescaler <= prescaler_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      // Load is independent of the scan; it only ever touches the shadow.
      if (load) shadow <= value;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench: main instance uses REFRESH_DIV=4/BLANK_CYCLES=1, a second one 1/0.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'b0000;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;
  logic [3:0]  an, an2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_mask(blank_mask),
    .seg(seg), .dp(dp), .an(an)
  );

  sevenseg_scan_driver #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_fast (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_mask(blank_mask),
    .seg(seg2), .dp(dp2), .an(an2)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[n];
  endfunction

  // t counts edges after reset release (t=1 is the first); slots are 4 lit + 1 dark.
  function automatic logic [3:0] exp_an(input int t, input logic [3:0] mask);
    int ph = (t - 1) % 5;
    int d  = ((t - 1) / 5) % 4;
    if (ph == 4 || mask[d]) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [6:0] exp_seg(input int t, input logic [15:0] sh, input logic [3:0] mask);
    int ph = (t - 1) % 5;
    int d  = ((t - 1) / 5) % 4;
    if (ph == 4 || mask[d]) return 7'b1111111;
    return glyph(sh[d*4 +: 4]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: an=%b seg=%b dp=%b, want 1111 1111111 1", i, an, seg, dp);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL first_after_reset: an=%b seg=%b dp=%b, want 1110 1000000 1", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    do_reset();
    value = 16'h3A5C;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL load_latency: an=%b seg=%b, want 1110 1000000", an, seg);
    end
    for (int t = 2; t <= 21; t++) begin
      step();
      n_cmp++;
      if (an !== exp_an(t, 4'b0000) || seg !== exp_seg(t, 16'h3A5C, 4'b0000) || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL scan t=%0d: an=%b seg=%b dp=%b, want %b %b 1", t, an, seg, dp,
                 exp_an(t, 4'b0000), exp_seg(t, 16'h3A5C, 4'b0000));
      end
    end
  endtask

  task automatic test_blank_mask();
    blank_mask = 4'b0100;
    do_reset();
    value = 16'h7012;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int t = 2; t <= 21; t++) begin
      step();
      n_cmp++;
      if (an !== exp_an(t, 4'b0100) || seg !== exp_seg(t, 16'h7012, 4'b0100)) begin
        n_fail++;
        $display("FAIL blank_mask t=%0d: an=%b seg=%b, want %b %b", t, an, seg,
                 exp_an(t, 4'b0100), exp_seg(t, 16'h7012, 4'b0100));
      end
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_midslot_load();
    do_reset();
    value = 16'h0008;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int t = 2; t <= 21; t++) step();
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b0000000) begin
      n_fail++;
      $display("FAIL midslot_old: an=%b seg=%b, want 1110 0000000", an, seg);
    end
    value = 16'h0001;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b0000000) begin
      n_fail++;
      $display("FAIL midslot_load_edge: an=%b seg=%b, want 1110 0000000", an, seg);
    end
    for (int t = 23; t <= 26; t++) begin
      step();
      n_cmp++;
      if (an !== exp_an(t, 4'b0000) || seg !== exp_seg(t, 16'h0001, 4'b0000)) begin
        n_fail++;
        $display("FAIL midslot t=%0d: an=%b seg=%b, want %b %b", t, an, seg,
                 exp_an(t, 4'b0000), exp_seg(t, 16'h0001, 4'b0000));
      end
    end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    value = 16'h7012;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int t = 2; t <= 11; t++) step();
    n_cmp++;
    if (an !== 4'b1011 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL pre_reset_digit2: an=%b seg=%b, want 1011 1000000", an, seg);
    end
    rst = 1'b1;
    value = 16'hFFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_reset_dark: an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
    end
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      step();
      n_cmp++;
      if (an !== exp_an(t, 4'b0000) || seg !== exp_seg(t, 16'h0000, 4'b0000)) begin
        n_fail++;
        $display("FAIL restart t=%0d: an=%b seg=%b, want %b %b", t, an, seg,
                 exp_an(t, 4'b0000), exp_seg(t, 16'h0000, 4'b0000));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    value = 16'h1111;
    load = 1'b1;
    step();
    value = 16'h2222;
    step();
    load = 1'b0;
    n_cmp++;
    if (seg !== 7'b1111001) begin
      n_fail++;
      $display("FAIL b2b_first: seg=%b, want 1111001", seg);
    end
    step();
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b0100100) begin
      n_fail++;
      $display("FAIL b2b_last_wins: an=%b seg=%b, want 1110 0100100", an, seg);
    end
    // Load on the terminal-count edge of digit 0's slot.
    do_reset();
    for (int t = 1; t <= 3; t++) step();
    value = 16'h0050;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL tc_load_edge: an=%b seg=%b, want 1110 1000000", an, seg);
    end
    step();
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'b1111111) begin
      n_fail++;
      $display("FAIL tc_load_gap: an=%b seg=%b, want 1111 1111111", an, seg);
    end
    step();
    n_cmp++;
    if (an !== 4'b1101 || seg !== 7'b0010010) begin
      n_fail++;
      $display("FAIL tc_load_next: an=%b seg=%b, want 1101 0010010", an, seg);
    end
  endtask

  task automatic test_no_blank();
    logic [3:0] want [5];
    want = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      step();
      n_cmp++;
      if (an2 !== want[t] || seg2 !== 7'b1000000 || dp2 !== 1'b1) begin
        n_fail++;
        $display("FAIL no_blank t=%0d: an=%b seg=%b dp=%b, want %b 1000000 1", t + 1, an2, seg2, dp2, want[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_mask();
    test_midslot_load();
    test_reset_midscan();
    test_back_to_back();
    test_no_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
